// File: rtl/jk_bank_scheduler_pkg.sv
// Shared command encodings and the round-robin pick helper for the JK bank scheduler.
// The helper is combinational; it takes no part in backpressure.
package jk_sched_pkg;
   localparam logic [1:0] CMD_HOLD = 2'b00;
   localparam logic [1:0] CMD_CLR  = 2'b01;
   localparam logic [1:0] CMD_SET  = 2'b10;
   localparam logic [1:0] CMD_TGL  = 2'b11;

   localparam int MAXREQ = 32;

   // Returns the first set bit of req_mask at or after ptr (wrapping mod n), or -1.
   function automatic int rr_pick(input logic [MAXREQ-1:0] req_mask, input int n, input int ptr);
      int w;
      int i;
      w = -1;
      for (int s = 0; s < MAXREQ; s++) begin
         i = ptr + s;
         if (i >= n) i = i - n;
         if (s < n && w < 0 && req_mask[i]) w = i;
      end
      return w;
   endfunction
endpackage

// File: rtl/jk_bank_scheduler_if.sv
// Requester/bank handshake bundle: level requests in, one-hot grant and done report out.
// Requesters hold req until they see their gnt bit; there is no other backpressure.
interface jk_bank_scheduler_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   localparam int IDXW = $clog2(WIDTH);
   localparam int IDW  = $clog2(NREQ);

   logic [NREQ-1:0]      req;
   logic [2*NREQ-1:0]    cmd;
   logic [IDXW*NREQ-1:0] idx;
   logic [NREQ-1:0]      gnt;
   logic                 done;
   logic [IDW-1:0]       done_id;
   logic                 done_q;
   logic                 done_err;
   logic [WIDTH-1:0]     q;
   logic                 busy;

   modport master (output req, cmd, idx,
                   input  gnt, done, done_id, done_q, done_err, q, busy);
   modport slave  (input  req, cmd, idx,
                   output gnt, done, done_id, done_q, done_err, q, busy);
endinterface

// File: rtl/jk_bank_scheduler_cell.sv
// One JK flip-flop cell of the shared bank, cleared by the async reset.
// Next state appears one edge after J/K; no backpressure.
module jk_cell (
   input  logic clk,
   input  logic rst,
   input  logic J,
   input  logic K,
   output logic Q
);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Q <= 1'b0;
      end else begin
         case ({J, K})
            2'b01:   Q <= 1'b0;
            2'b10:   Q <= 1'b1;
            2'b11:   Q <= ~Q;
            default: Q <= Q;
         endcase
      end
   end
endmodule

// File: rtl/jk_bank_scheduler.sv
// Round-robin shares a JK bank between requesters; gnt one edge after req, q/done one edge later.
// One command per cycle; the grant holder is masked for a cycle so it cannot be double-granted.
module jk_bank_scheduler
   import jk_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   jk_bank_scheduler_if.slave bus
);
   localparam int IDXW = $clog2(WIDTH);
   localparam int IDW  = $clog2(NREQ);
   localparam logic [IDXW:0] WLIM = (IDXW+1)'(WIDTH);

   logic [NREQ-1:0]  gnt_r;
   logic [NREQ-1:0]  elig;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   win;
   logic             found;
   int               pick;

   logic             a_vld;
   logic [1:0]       a_cmd;
   logic [IDXW-1:0]  a_idx;
   logic [IDW-1:0]   a_id;

   logic [WIDTH-1:0] sel;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] q;
   logic             a_err;
   logic             cur_bit;
   logic             nxt_bit;

   logic             done_r;
   logic [IDW-1:0]   done_id_r;
   logic             done_q_r;
   logic             done_err_r;

   always_comb begin
      elig  = bus.req & ~gnt_r;
      pick  = rr_pick(MAXREQ'(elig), NREQ, int'(ptr));
      found = (pick >= 0);
      win   = IDW'(pick);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt_r <= '0;
         ptr   <= '0;
         a_vld <= 1'b0;
         a_cmd <= CMD_HOLD;
         a_idx <= '0;
         a_id  <= '0;
      end else begin
         a_vld <= found;
         gnt_r <= found ? (NREQ'(1) << win) : '0;
         if (found) begin
            a_cmd <= bus.cmd[2*int'(win) +: 2];
            a_idx <= bus.idx[IDXW*int'(win) +: IDXW];
            a_id  <= win;
            ptr   <= (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
         end
      end
   end

   // An out-of-range index decodes to no cell, so the bank is left untouched.
   always_comb begin
      sel = '0;
      for (int c = 0; c < WIDTH; c++) sel[c] = a_vld && (a_idx == IDXW'(c));
      a_err   = a_vld && ({1'b0, a_idx} >= WLIM);
      j       = sel & {WIDTH{a_cmd[1]}};
      k       = sel & {WIDTH{a_cmd[0]}};
      cur_bit = |(q & sel);
      case (a_cmd)
         CMD_CLR: nxt_bit = 1'b0;
         CMD_SET: nxt_bit = 1'b1;
         CMD_TGL: nxt_bit = ~cur_bit;
         default: nxt_bit = cur_bit;
      endcase
   end

   for (genvar c = 0; c < WIDTH; c++) begin : g_cell
      jk_cell u_cell (.clk(clk), .rst(rst), .J(j[c]), .K(k[c]), .Q(q[c]));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_r     <= 1'b0;
         done_id_r  <= '0;
         done_q_r   <= 1'b0;
         done_err_r <= 1'b0;
      end else begin
         done_r     <= a_vld;
         done_id_r  <= a_id;
         done_q_r   <= a_vld && !a_err && nxt_bit;
         done_err_r <= a_err;
      end
   end

   assign bus.gnt      = gnt_r;
   assign bus.done     = done_r;
   assign bus.done_id  = done_id_r;
   assign bus.done_q   = done_q_r;
   assign bus.done_err = done_err_r;
   assign bus.q        = q;
   assign bus.busy     = a_vld | done_r;
endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Bench for jk_bank_scheduler: directed vector tables and sequences plus randomized
// traffic checked against a queue-free behavioural model of grant order and bank state.
module tb_jk_bank_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jk_bank_scheduler_if #(.NREQ(4), .WIDTH(8)) b0 ();
   jk_bank_scheduler_if #(.NREQ(4), .WIDTH(6)) b1 ();

   jk_bank_scheduler #(.NREQ(4), .WIDTH(8)) u0 (.clk(clk), .rst(rst), .bus(b0));
   jk_bank_scheduler #(.NREQ(4), .WIDTH(6)) u1 (.clk(clk), .rst(rst), .bus(b1));

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model of u0: bank contents, pointer, last grant, one in-flight command.
   logic [7:0] m_q;
   int         m_ptr;
   logic [3:0] m_gnt;
   bit         p_v;
   int         p_id;
   logic [1:0] p_cmd;
   int         p_idx;
   bit         m_done;
   int         m_id;
   bit         m_dq;
   bit         m_err;

   typedef struct {
      bit         rst_first;
      logic [3:0] req;
      logic [7:0] cmd;
      logic [11:0] idx;
      logic [3:0] gnt;
      bit         done;
      int         id;
      bit         dq;
      logic [7:0] q;
      bit         busy;
   } vec_t;
   vec_t tbl[12];

   function automatic vec_t mk(bit r, logic [3:0] rq, logic [7:0] c, logic [11:0] ix,
                               logic [3:0] g, bit d, int id, bit dq, logic [7:0] q, bit b);
      vec_t v;
      v.rst_first = r; v.req = rq; v.cmd = c; v.idx = ix; v.gnt = g;
      v.done = d; v.id = id; v.dq = dq; v.q = q; v.busy = b;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q = 8'h00; m_ptr = 0; m_gnt = 4'h0; p_v = 0; m_done = 0; m_err = 0; m_dq = 0; m_id = 0;
   endtask

   task automatic model_edge();
      logic [3:0] elig;
      bit found;
      m_done = p_v;
      m_err  = 0;
      if (p_v) begin
         m_id = p_id;
         if (p_idx >= 8) begin
            m_err = 1; m_dq = 0;
         end else begin
            case (p_cmd)
               2'b01: m_q[p_idx] = 1'b0;
               2'b10: m_q[p_idx] = 1'b1;
               2'b11: m_q[p_idx] = ~m_q[p_idx];
               default: ;
            endcase
            m_dq = m_q[p_idx];
         end
      end
      elig  = b0.req & ~m_gnt;
      found = 0;
      m_gnt = 4'h0;
      for (int s = 0; s < 4; s++) begin
         int i;
         i = (m_ptr + s) % 4;
         if (!found && elig[i]) begin
            found = 1; p_id = i; p_cmd = b0.cmd[2*i +: 2]; p_idx = int'(b0.idx[3*i +: 3]);
            m_gnt[i] = 1'b1; m_ptr = (i + 1) % 4;
         end
      end
      p_v = found;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cyc();
      model_edge();
      tick();
      chk("gnt", int'(b0.gnt), int'(m_gnt));
      chk("done", int'(b0.done), int'(m_done));
      chk("q", int'(b0.q), int'(m_q));
      chk("busy", int'(b0.busy), int'(p_v | m_done));
      if (m_done) begin
         chk("done_id", int'(b0.done_id), m_id);
         chk("done_q", int'(b0.done_q), int'(m_dq));
         chk("done_err", int'(b0.done_err), int'(m_err));
      end
   endtask

   task automatic do_reset();
      b0.req = '0; b1.req = '0;
      rst = 1'b0;
      #3;
      chk("rst_q", int'(b0.q), 0);
      chk("rst_gnt", int'(b0.gnt), 0);
      chk("rst_done", int'(b0.done), 0);
      chk("rst_busy", int'(b0.busy), 0);
      chk("rst_outs", int'({b0.done_id, b0.done_q, b0.done_err}), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit prev0, got;
      int waited;
      b0.req = '0; b0.cmd = '0; b0.idx = '0;
      b1.req = '0; b1.cmd = '0; b1.idx = '0;
      model_reset();
      @(negedge clk);
      do_reset();

      // Each requester in turn sets its own bit.
      for (int i = 0; i < 4; i++) begin
         b0.req = 4'(1 << i);
         b0.cmd = 8'(2 << (2*i));
         b0.idx = 12'(i << (3*i));
         cyc();
         chk("t1_gnt", int'(b0.gnt), 1 << i);
         b0.req = '0;
         cyc();
         chk("t1_done", int'(b0.done), 1);
         chk("t1_id", int'(b0.done_id), i);
         cyc();
      end
      chk("t1_q", int'(b0.q), 8'h0F);

      // Four simultaneous toggles, then SET/TGL/TGL/CLR on bit 5.
      tbl[0]  = mk(1, 4'hF, 8'hFF, 12'h688, 4'h1, 0, 0, 0, 8'h00, 1);
      tbl[1]  = mk(0, 4'hE, 8'hFF, 12'h688, 4'h2, 1, 0, 1, 8'h01, 1);
      tbl[2]  = mk(0, 4'hC, 8'hFF, 12'h688, 4'h4, 1, 1, 1, 8'h03, 1);
      tbl[3]  = mk(0, 4'h8, 8'hFF, 12'h688, 4'h8, 1, 2, 1, 8'h07, 1);
      tbl[4]  = mk(0, 4'h0, 8'hFF, 12'h688, 4'h0, 1, 3, 1, 8'h0F, 1);
      tbl[5]  = mk(0, 4'h0, 8'hFF, 12'h688, 4'h0, 0, 0, 0, 8'h0F, 0);
      tbl[6]  = mk(1, 4'hF, 8'h7E, 12'hB6D, 4'h1, 0, 0, 0, 8'h00, 1);
      tbl[7]  = mk(0, 4'hE, 8'h7E, 12'hB6D, 4'h2, 1, 0, 1, 8'h20, 1);
      tbl[8]  = mk(0, 4'hC, 8'h7E, 12'hB6D, 4'h4, 1, 1, 0, 8'h00, 1);
      tbl[9]  = mk(0, 4'h8, 8'h7E, 12'hB6D, 4'h8, 1, 2, 1, 8'h20, 1);
      tbl[10] = mk(0, 4'h0, 8'h7E, 12'hB6D, 4'h0, 1, 3, 0, 8'h00, 1);
      tbl[11] = mk(0, 4'h0, 8'h7E, 12'hB6D, 4'h0, 0, 0, 0, 8'h00, 0);
      for (int r = 0; r < 12; r++) begin
         if (tbl[r].rst_first) do_reset();
         b0.req = tbl[r].req; b0.cmd = tbl[r].cmd; b0.idx = tbl[r].idx;
         cyc();
         chk("tv_gnt", int'(b0.gnt), int'(tbl[r].gnt));
         chk("tv_done", int'(b0.done), int'(tbl[r].done));
         chk("tv_q", int'(b0.q), int'(tbl[r].q));
         chk("tv_busy", int'(b0.busy), int'(tbl[r].busy));
         if (tbl[r].done) begin
            chk("tv_id", int'(b0.done_id), tbl[r].id);
            chk("tv_dq", int'(b0.done_q), int'(tbl[r].dq));
         end
      end

      // Reset while both stages hold a command.
      b0.req = 4'b0100; b0.cmd = 8'b00_10_10_00; b0.idx = 12'(6 << 6) | 12'(3 << 3);
      cyc();
      b0.req = 4'b0010;
      cyc();
      rst = 1'b0;
      #1;
      chk("t6_q", int'(b0.q), 0);
      chk("t6_gnt", int'(b0.gnt), 0);
      chk("t6_done", int'(b0.done), 0);
      chk("t6_busy", int'(b0.busy), 0);
      model_reset();
      b0.req = 4'hF; b0.cmd = '0; b0.idx = '0;
      @(negedge clk);
      rst = 1'b1;
      cyc();
      chk("t6_first_gnt", int'(b0.gnt), 1);
      chk("t6_no_done", int'(b0.done), 0);
      b0.req = '0;
      cyc();
      cyc();

      // Requester 0 holds req; requester 1 pulses once.
      do_reset();
      b0.req = 4'b0001; b0.cmd = '0; b0.idx = '0;
      prev0 = 0; got = 0; waited = 0;
      for (int c = 0; c < 12; c++) begin
         if (c == 4) begin
            b0.req[1] = 1'b1; b0.cmd[3:2] = 2'b10; b0.idx[5:3] = 3'd1;
         end else if (m_gnt[1]) begin
            b0.req[1] = 1'b0;
         end
         cyc();
         chk("t3_gnt0_gap", int'(b0.gnt[0] & prev0), 0);
         prev0 = b0.gnt[0];
         if (b0.req[1] && !got) begin
            waited++;
            if (b0.gnt[1]) got = 1;
         end
      end
      chk("t3_req1_wait", int'(got && waited <= 2), 1);
      b0.req = '0;
      cyc();
      cyc();

      // Out-of-range index on the 6-bit bank.
      do_reset();
      b1.req = 4'b0001; b1.cmd = 8'h02; b1.idx = 12'd5;
      tick();
      chk("t5_gnt", int'(b1.gnt), 1);
      b1.req = '0;
      tick();
      chk("t5_ok_done", int'(b1.done), 1);
      chk("t5_ok_err", int'(b1.done_err), 0);
      chk("t5_ok_q", int'(b1.q), 6'h20);
      b1.req = 4'b0001; b1.idx = 12'd7;
      tick();
      b1.req = '0;
      tick();
      chk("t5_done", int'(b1.done), 1);
      chk("t5_err", int'(b1.done_err), 1);
      chk("t5_dq", int'(b1.done_q), 0);
      chk("t5_q", int'(b1.q), 6'h20);
      tick();
      chk("t5_idle", int'(b1.busy), 0);

      // Randomized traffic against the model.
      do_reset();
      b0.cmd = '0; b0.idx = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (m_gnt[i]) begin
               if ($urandom_range(1, 0) == 1) begin
                  b0.cmd[2*i +: 2] = 2'($urandom);
                  b0.idx[3*i +: 3] = 3'($urandom);
               end else begin
                  b0.req[i] = 1'b0;
               end
            end else if (!b0.req[i] && $urandom_range(2, 0) == 0) begin
               b0.req[i] = 1'b1;
               b0.cmd[2*i +: 2] = 2'($urandom);
               b0.idx[3*i +: 3] = 3'($urandom);
            end
         end
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
